// File: rtl/status_wb_pkg.sv
// rtl/status_wb_pkg.sv - shared constants and FSM encoding for the status writeback stage
package status_wb_pkg;

    // Destination encoding carried with each issued op
    localparam logic [1:0] DEST_A   = 2'd0;
    localparam logic [1:0] DEST_X   = 2'd1;
    localparam logic [1:0] DEST_Y   = 2'd2;
    localparam logic [1:0] DEST_MEM = 2'd3;

    // Processor status bit positions (NV--DIZC)
    localparam int PSR_N = 7;
    localparam int PSR_V = 6;
    localparam int PSR_D = 3;
    localparam int PSR_I = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_C = 0;

    // Bits 5 and 4 have no storage; every merge mask is clipped to this set
    localparam logic [7:0] PSR_STORE_MASK = 8'((1 << PSR_N) | (1 << PSR_V) | (1 << PSR_D) |
                                               (1 << PSR_I) | (1 << PSR_Z) | (1 << PSR_C));
    // Bit 5 always reads as one
    localparam logic [7:0] PSR_FORCE_ONE  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/psr_merge.sv
// rtl/psr_merge.sv - masked merge of new status bits into an old status value
//  old_i    : current stored P
//  new_i    : candidate bit values
//  mask_i   : bits allowed to change (bits 5/4 ignored)
//  merged_o : resulting stored P (bits 5/4 always zero)
module psr_merge
    import status_wb_pkg::*;
(
    input  logic [7:0] old_i,
    input  logic [7:0] new_i,
    input  logic [7:0] mask_i,
    output logic [7:0] merged_o
);

    logic [7:0] eff_mask;

    assign eff_mask = mask_i & PSR_STORE_MASK;
    assign merged_o = ((old_i & ~eff_mask) | (new_i & eff_mask)) & PSR_STORE_MASK;

endmodule

// File: rtl/status_writeback.sv
// rtl/status_writeback.sv - commit stage after the registered ALU: flag merge, register and memory writeback
//  Optional macro: STATUS_WB_CHECK_EN adds simulation-only protocol checks.
//  clk, rst_n                  : clock, asynchronous active-low reset
//  issue_valid/ready/dest/mask : op issue handshake, destination, P update mask
//  alu_result, alu_psr         : ALU outputs, valid during EXEC
//  flag_wr_en/mask/data        : direct P write, honoured only while idle
//  a_out, x_out, y_out, p_out  : architectural registers
//  carry_out, decimal_out      : P[C], P[D] back to the ALU
//  mem_wr_valid/data/ready     : memory write request
module status_writeback
    import status_wb_pkg::*;
#(
    parameter logic [7:0] P_RESET = 8'h24,
    parameter logic [7:0] A_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [1:0] issue_dest,
    input  logic [7:0] issue_mask,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_psr,
    input  logic       flag_wr_en,
    input  logic [7:0] flag_wr_mask,
    input  logic [7:0] flag_wr_data,
    output logic [7:0] a_out,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic [7:0] p_out,
    output logic       carry_out,
    output logic       decimal_out,
    output logic       mem_wr_valid,
    output logic [7:0] mem_wr_data,
    input  logic       mem_wr_ready
);

    state_e     state_q, state_d;
    logic [1:0] dest_q, dest_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] a_q, a_d, x_q, x_d, y_q, y_d;
    logic [7:0] p_q, p_d;
    logic       mem_valid_q, mem_valid_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic [7:0] exec_p, flag_p;

    psr_merge u_exec_merge (
        .old_i    (p_q),
        .new_i    (alu_psr),
        .mask_i   (mask_q),
        .merged_o (exec_p)
    );

    psr_merge u_flag_merge (
        .old_i    (p_q),
        .new_i    (flag_wr_data),
        .mask_i   (flag_wr_mask),
        .merged_o (flag_p)
    );

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        mask_d      = mask_q;
        a_d         = a_q;
        x_d         = x_q;
        y_d         = y_q;
        p_d         = p_q;
        mem_valid_d = mem_valid_q;
        mem_data_d  = mem_data_q;
        case (state_q)
            ST_IDLE: begin
                // A flag write accepted with an issue lands first; the EXEC merge follows a cycle later
                if (flag_wr_en) begin
                    p_d = flag_p;
                end
                if (issue_valid) begin
                    dest_d  = issue_dest;
                    mask_d  = issue_mask;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                p_d     = exec_p;
                state_d = ST_IDLE;
                case (dest_q)
                    DEST_A:  a_d = alu_result;
                    DEST_X:  x_d = alu_result;
                    DEST_Y:  y_d = alu_result;
                    default: begin
                        mem_data_d  = alu_result;
                        mem_valid_d = 1'b1;
                        state_d     = ST_MEM_WAIT;
                    end
                endcase
            end
            ST_MEM_WAIT: begin
                if (mem_wr_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dest_q      <= DEST_A;
            mask_q      <= 8'h00;
            a_q         <= A_RESET;
            x_q         <= A_RESET;
            y_q         <= A_RESET;
            p_q         <= P_RESET & PSR_STORE_MASK;
            mem_valid_q <= 1'b0;
            mem_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            mask_q      <= mask_d;
            a_q         <= a_d;
            x_q         <= x_d;
            y_q         <= y_d;
            p_q         <= p_d;
            mem_valid_q <= mem_valid_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign issue_ready  = (state_q == ST_IDLE);
    assign a_out        = a_q;
    assign x_out        = x_q;
    assign y_out        = y_q;
    assign p_out        = (p_q & PSR_STORE_MASK) | PSR_FORCE_ONE;
    assign carry_out    = p_q[PSR_C];
    assign decimal_out  = p_q[PSR_D];
    assign mem_wr_valid = mem_valid_q;
    assign mem_wr_data  = mem_data_q;

`ifdef STATUS_WB_CHECK_EN
    logic       chk_hold_q;
    logic [7:0] chk_data_q;

    always @(posedge clk) begin
        if (rst_n) begin
            if (issue_valid && !issue_ready)
                $error("status_writeback: issue_valid while not ready");
            if (state_q == ST_EXEC && ($isunknown(alu_result) || $isunknown(alu_psr)))
                $error("status_writeback: unknown ALU output in EXEC");
            if (chk_hold_q && (mem_wr_data != chk_data_q))
                $error("status_writeback: mem_wr_data changed under backpressure");
            if (issue_valid && issue_ready && issue_dest == DEST_MEM && issue_mask[PSR_D])
                $error("status_writeback: MEM op with D in mask");
        end
        chk_hold_q <= rst_n && mem_wr_valid && !mem_wr_ready;
        chk_data_q <= mem_wr_data;
    end
`endif

endmodule

// File: tb/tb_status_writeback.sv
// tb/tb_status_writeback.sv - self-checking bench for status_writeback
module tb_status_writeback;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_ready;
    logic [1:0] issue_dest;
    logic [7:0] issue_mask, alu_result, alu_psr;
    logic       flag_wr_en;
    logic [7:0] flag_wr_mask, flag_wr_data;
    logic [7:0] a_out, x_out, y_out, p_out;
    logic       carry_out, decimal_out;
    logic       mem_wr_valid, mem_wr_ready;
    logic [7:0] mem_wr_data;

    always #5 clk = ~clk;

    status_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_dest   (issue_dest),
        .issue_mask   (issue_mask),
        .alu_result   (alu_result),
        .alu_psr      (alu_psr),
        .flag_wr_en   (flag_wr_en),
        .flag_wr_mask (flag_wr_mask),
        .flag_wr_data (flag_wr_data),
        .a_out        (a_out),
        .x_out        (x_out),
        .y_out        (y_out),
        .p_out        (p_out),
        .carry_out    (carry_out),
        .decimal_out  (decimal_out),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready)
    );

    typedef struct {
        logic [1:0] dest;
        logic [7:0] data;
        logic [7:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] mp, ma, mx, my;

    // Visible P after a masked merge: bit5 reads 1, bit4 reads 0
    function automatic logic [7:0] pmerge(input logic [7:0] o, input logic [7:0] n, input logic [7:0] m);
        logic [7:0] k;
        k = m & 8'hCF;
        return (((o & ~k) | (n & k)) & 8'hEF) | 8'h20;
    endfunction

    // Presents one op in IDLE, supplies ALU outputs in EXEC, returns #1 after the commit edge
    task automatic drive_issue(input logic [1:0] d, input logic [7:0] m, input logic [7:0] r, input logic [7:0] ps);
        exp_t e;
        issue_valid = 1'b1;
        issue_dest  = d;
        issue_mask  = m;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        alu_result  = r;
        alu_psr     = ps;
        mp = pmerge(mp, ps, m);
        case (d)
            2'd0: ma = r;
            2'd1: mx = r;
            2'd2: my = r;
            default: ;
        endcase
        e.dest = d; e.data = r; e.p = mp;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        mp = 8'h24; ma = 8'h00; mx = 8'h00; my = 8'h00;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_dest = 2'd0; issue_mask = 8'h00;
        alu_result = 8'h00; alu_psr = 8'h00;
        flag_wr_en = 1'b0; flag_wr_mask = 8'h00; flag_wr_data = 8'h00;
        mem_wr_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (p_out !== 8'h24) begin n_fail++; $display("FAIL reset_p: got %h expected %h", p_out, 8'h24); end
        n_tests++; if ({a_out, x_out, y_out} !== 24'h0) begin n_fail++; $display("FAIL reset_axy: got %h expected %h", {a_out, x_out, y_out}, 24'h0); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", issue_ready); end
        n_tests++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", mem_wr_valid); end
        n_tests++; if ({carry_out, decimal_out} !== 2'b00) begin n_fail++; $display("FAIL reset_cd: got %b expected 00", {carry_out, decimal_out}); end
    endtask

    task automatic test_adc_commit();
        exp_t e;
        drive_issue(2'd0, 8'hC3, 8'h80, 8'h41);
        e = sb.pop_front();
        n_tests++; if (a_out !== e.data) begin n_fail++; $display("FAIL adc_a: got %h expected %h", a_out, e.data); end
        n_tests++; if (p_out !== 8'h65) begin n_fail++; $display("FAIL adc_p: got %h expected %h", p_out, 8'h65); end
        n_tests++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL adc_carry: got %b expected 1", carry_out); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL adc_ready: got %b expected 1", issue_ready); end
    endtask

    task automatic test_mask_filter();
        exp_t e;
        drive_issue(2'd1, 8'hFF, 8'h3C, 8'hFF);
        e = sb.pop_front();
        n_tests++; if (x_out !== e.data) begin n_fail++; $display("FAIL maskf_x: got %h expected %h", x_out, e.data); end
        n_tests++; if (p_out !== 8'hEF) begin n_fail++; $display("FAIL maskf_p: got %h expected %h", p_out, 8'hEF); end
        n_tests++; if (decimal_out !== 1'b1) begin n_fail++; $display("FAIL maskf_dec: got %b expected 1", decimal_out); end
        // Full-mask direct write with bit4 set in the data: bit4 must still read 0
        flag_wr_en = 1'b1; flag_wr_mask = 8'hFF; flag_wr_data = 8'h34;
        @(posedge clk); #1;
        flag_wr_en = 1'b0;
        mp = pmerge(mp, 8'h34, 8'hFF);
        n_tests++; if (p_out !== 8'h24) begin n_fail++; $display("FAIL maskf_restore: got %h expected %h", p_out, 8'h24); end
    endtask

    task automatic test_flag_write();
        exp_t e;
        flag_wr_en = 1'b1; flag_wr_mask = 8'h01; flag_wr_data = 8'h01;
        @(posedge clk); #1;
        mp = pmerge(mp, 8'h01, 8'h01);
        n_tests++; if (p_out !== 8'h25) begin n_fail++; $display("FAIL sec_p: got %h expected %h", p_out, 8'h25); end
        flag_wr_data = 8'h00;
        @(posedge clk); #1;
        mp = pmerge(mp, 8'h00, 8'h01);
        n_tests++; if (p_out !== 8'h24) begin n_fail++; $display("FAIL clc_p: got %h expected %h", p_out, 8'h24); end
        // SEC together with an issue: flag lands at E1, EXEC merge clears C at E2; SED during EXEC is ignored
        flag_wr_data = 8'h01;
        issue_valid = 1'b1; issue_dest = 2'd2; issue_mask = 8'h01;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        flag_wr_mask = 8'h08; flag_wr_data = 8'h08;
        alu_result = 8'h77; alu_psr = 8'h00;
        n_tests++; if (p_out !== 8'h25) begin n_fail++; $display("FAIL conc_p_e1: got %h expected %h", p_out, 8'h25); end
        @(posedge clk); #1;
        flag_wr_en = 1'b0;
        my = 8'h77;
        e.dest = 2'd2; e.data = 8'h77; e.p = 8'h24;
        sb.push_back(e);
        e = sb.pop_front();
        n_tests++; if (p_out !== e.p) begin n_fail++; $display("FAIL conc_p_e2: got %h expected %h", p_out, e.p); end
        n_tests++; if (y_out !== e.data) begin n_fail++; $display("FAIL conc_y: got %h expected %h", y_out, e.data); end
        n_tests++; if (decimal_out !== 1'b0) begin n_fail++; $display("FAIL exec_flag_ignored: got %b expected 0", decimal_out); end
    endtask

    task automatic test_interlock();
        int   accepts;
        logic exp_r;
        accepts = 0;
        issue_valid = 1'b1; issue_dest = 2'd0; issue_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp_r = (i % 2 == 0);
            n_tests++; if (issue_ready !== exp_r) begin n_fail++; $display("FAIL interlock_ready_%0d: got %b expected %b", i, issue_ready, exp_r); end
            if (issue_ready === 1'b1) accepts++;
            alu_result = 8'(8'h10 + i);
            alu_psr    = 8'hFF;
            @(posedge clk); #1;
            if (i % 2 == 1) begin
                ma = 8'(8'h10 + i);
                n_tests++; if (a_out !== ma) begin n_fail++; $display("FAIL interlock_a_%0d: got %h expected %h", i, a_out, ma); end
            end
        end
        issue_valid = 1'b0;
        n_tests++; if (accepts !== 4) begin n_fail++; $display("FAIL interlock_count: got %0d expected 4", accepts); end
        n_tests++; if (p_out !== mp) begin n_fail++; $display("FAIL interlock_p: got %h expected %h", p_out, mp); end
    endtask

    task automatic test_mem_backpressure();
        exp_t e;
        int   vcyc;
        vcyc = 0;
        mem_wr_ready = 1'b0;
        drive_issue(2'd3, 8'h00, 8'h5A, 8'h00);
        flag_wr_en = 1'b1; flag_wr_mask = 8'h01; flag_wr_data = 8'h01;
        for (int c = 0; c < 20; c++) begin
            if (mem_wr_valid !== 1'b1) break;
            vcyc++;
            n_tests++; if (mem_wr_data !== 8'h5A) begin n_fail++; $display("FAIL mem_data_c%0d: got %h expected %h", c, mem_wr_data, 8'h5A); end
            n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL mem_ready_c%0d: got %b expected 0", c, issue_ready); end
            mem_wr_ready = (c == 3);
            if (c == 3 && sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++; if (mem_wr_data !== e.data) begin n_fail++; $display("FAIL mem_accept_data: got %h expected %h", mem_wr_data, e.data); end
            end
            @(posedge clk); #1;
        end
        flag_wr_en = 1'b0; mem_wr_ready = 1'b0;
        n_tests++; if (vcyc !== 4) begin n_fail++; $display("FAIL mem_valid_cycles: got %0d expected 4", vcyc); end
        n_tests++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL mem_valid_drop: got %b expected 0", mem_wr_valid); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL mem_ready_after: got %b expected 1", issue_ready); end
        n_tests++; if (p_out !== mp) begin n_fail++; $display("FAIL mem_wait_flag_ignored: got %h expected %h", p_out, mp); end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [1:0] d;
        logic [7:0] m, got;
        mem_wr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            d = 2'($urandom_range(0, 3));
            m = 8'($urandom);
            if (d == 2'd3) m[3] = 1'b0;
            drive_issue(d, m, 8'($urandom), 8'($urandom));
            e = sb.pop_front();
            if (d == 2'd3) begin
                n_tests++; if (mem_wr_valid !== 1'b1 || mem_wr_data !== e.data) begin n_fail++; $display("FAIL b2b_mem_%0d: got %b/%h expected 1/%h", k, mem_wr_valid, mem_wr_data, e.data); end
                @(posedge clk); #1;
                n_tests++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_mem_drop_%0d: got %b expected 0", k, mem_wr_valid); end
            end else begin
                got = (d == 2'd0) ? a_out : (d == 2'd1) ? x_out : y_out;
                n_tests++; if (got !== e.data) begin n_fail++; $display("FAIL b2b_reg_%0d: got %h expected %h", k, got, e.data); end
            end
            n_tests++; if (p_out !== e.p || carry_out !== e.p[0]) begin n_fail++; $display("FAIL b2b_p_%0d: got %h/%b expected %h/%b", k, p_out, carry_out, e.p, e.p[0]); end
        end
        mem_wr_ready = 1'b0;
        n_tests++; if ({a_out, x_out, y_out} !== {ma, mx, my}) begin n_fail++; $display("FAIL b2b_axy: got %h expected %h", {a_out, x_out, y_out}, {ma, mx, my}); end
    endtask

    task automatic test_reset_mid_mem();
        drive_issue(2'd0, 8'h00, 8'h99, 8'h00);
        drive_issue(2'd1, 8'hC3, 8'h42, 8'hC3);
        mem_wr_ready = 1'b0;
        drive_issue(2'd3, 8'h00, 8'hA5, 8'h00);
        @(posedge clk); #1;
        n_tests++; if (mem_wr_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_valid: got %b expected 1", mem_wr_valid); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", mem_wr_valid); end
        n_tests++; if (p_out !== 8'h24) begin n_fail++; $display("FAIL rst_mid_p: got %h expected %h", p_out, 8'h24); end
        n_tests++; if ({a_out, x_out, y_out} !== 24'h0) begin n_fail++; $display("FAIL rst_mid_axy: got %h expected %h", {a_out, x_out, y_out}, 24'h0); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", issue_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard: got %b expected 0", mem_wr_valid); end
        mem_wr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_adc_commit();
        test_mask_filter();
        test_flag_write();
        test_interlock();
        test_mem_backpressure();
        test_back_to_back();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
